audio_recorder: RTL and testbench

AUDIO_RECORDER -- requirements
Module: audio_recorder

---
 rtl/audio_pkg.sv | 37 +++
 rtl/mic_spi_rx.sv | 90 +++++++++
 rtl/audio_recorder.sv | 149 ++++++++++++++
 tb/tb_audio_recorder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared constants for the audio record/playback blocks:
//               default timing parameters, sample/address widths, recorder
//               FSM state encoding and the ADC-code-to-PCM conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Defaults for a 100 MHz system clock.
    localparam int c_HOLD_TIME_DEF = 31250;  // clk cycles per sample period
    localparam int c_MUSIC_LEN_DEF = 64000;  // samples per recording
    localparam int c_SCLK_HALF_DEF = 25;     // clk cycles per SCLK half-period

    localparam int c_CODE_BITS   = 12;       // ADC resolution
    localparam int c_ADC_FRAME   = 16;       // SCLK periods per conversion
    localparam int c_SAMPLE_BITS = 16;       // stored sample width
    localparam int c_ADDR_BITS   = 16;       // sample memory address width

    // Recorder FSM encoding.
    localparam int              c_STATE_W  = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_CONV  = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_WRITE = 2'd3;

    // Offset-binary code -> signed PCM: (code - 2048) << 4. Subtracting the
    // mid-scale value is the same as inverting the code MSB.
    function automatic logic [c_SAMPLE_BITS-1:0] code_to_pcm(
        input logic [c_CODE_BITS-1:0] code
    );
        return {~code[c_CODE_BITS-1], code[c_CODE_BITS-2:0], 4'b0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mic_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : mic_spi_rx
// Description : Serial capture from the microphone ADC. A go pulse drops
//               cs_n and clocks 16 full SCLK periods (idle high, starting
//               low); sdata is sampled on each rising SCLK edge, MSB first.
//               The low 12 captured bits are presented on data with a
//               one-cycle valid when cs_n is released.
// Ports       : clk, rst (sync, active-high), go, sdata  -> inputs
//               cs_n, sclk, data[11:0], valid             -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mic_spi_rx
    import audio_pkg::*;
#(
    parameter int SCLK_HALF = c_SCLK_HALF_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   sdata,
    output logic                   cs_n,
    output logic                   sclk,
    output logic [c_CODE_BITS-1:0] data,
    output logic                   valid
);

    localparam int c_CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCLK_HALF - 1);
    localparam logic [4:0]         c_NBITS   = 5'(c_ADC_FRAME);

    logic                   r_active;
    logic                   r_cs_n;
    logic                   r_sclk;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [4:0]             r_nbits;
    // Only 12 bits are kept: the four leading bits shift out unused.
    logic [c_CODE_BITS-1:0] r_shift;
    logic [c_CODE_BITS-1:0] r_data;
    logic                   r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b1;
            r_cnt    <= '0;
            r_nbits  <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (go) begin
                r_active <= 1'b1;
                r_cs_n   <= 1'b0;
                r_sclk   <= 1'b0;
                r_cnt    <= '0;
                r_nbits  <= '0;
            end else if (r_active) begin
                if (r_cnt == c_CNT_MAX) begin
                    r_cnt <= '0;
                    if (r_nbits == c_NBITS) begin
                        // High half of the 16th period has elapsed: SCLK is
                        // left high (its idle level) and the frame closes.
                        r_active <= 1'b0;
                        r_cs_n   <= 1'b1;
                        r_data   <= r_shift;
                        r_valid  <= 1'b1;
                    end else begin
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_shift <= {r_shift[c_CODE_BITS-2:0], sdata};
                            r_nbits <= r_nbits + 5'd1;
                        end
                    end
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign cs_n  = r_cs_n;
    assign sclk  = r_sclk;
    assign data  = r_data;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/audio_recorder.sv
`default_nettype none
// ============================================================================
// Module      : audio_recorder
// Description : Records MUSIC_LEN microphone samples, one every HOLD_TIME
//               clk cycles, into an external 16-bit sample memory. Owns the
//               sample-period timer, write address and record FSM; the ADC
//               serial transfer is done by mic_spi_rx.
// Ports       : clk, rst (sync, active-high), start (pulse), abort (level),
//               mic_sdata                              -> inputs
//               mic_cs_n, mic_sclk, mem_we, mem_addr[15:0],
//               mem_din[15:0], busy, done (pulse)      -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module audio_recorder
    import audio_pkg::*;
#(
    parameter int HOLD_TIME = c_HOLD_TIME_DEF,
    parameter int MUSIC_LEN = c_MUSIC_LEN_DEF,
    parameter int SCLK_HALF = c_SCLK_HALF_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mic_sdata,
    output logic                     mic_cs_n,
    output logic                     mic_sclk,
    output logic                     mem_we,
    output logic [c_ADDR_BITS-1:0]   mem_addr,
    output logic [c_SAMPLE_BITS-1:0] mem_din,
    output logic                     busy,
    output logic                     done
);

    localparam int c_TIMER_W = (HOLD_TIME > 1) ? $clog2(HOLD_TIME) : 1;
    localparam logic [c_TIMER_W-1:0]   c_TIMER_MAX = c_TIMER_W'(HOLD_TIME - 1);
    localparam logic [c_ADDR_BITS-1:0] c_LAST_ADDR = c_ADDR_BITS'(MUSIC_LEN - 1);

    // Conversion (32 half-periods) plus the WRITE handoff must finish before
    // the next timer wrap, otherwise that wrap is missed in WAIT.
    generate
        if (2 * c_ADC_FRAME * SCLK_HALF + 2 >= HOLD_TIME) begin : g_bad_timing
            $error("audio_recorder: ADC transaction does not fit in HOLD_TIME");
        end
    endgenerate

    logic [c_STATE_W-1:0]     r_state;
    logic [c_TIMER_W-1:0]     r_timer;
    logic [c_ADDR_BITS-1:0]   r_addr;
    logic [c_SAMPLE_BITS-1:0] r_din;
    logic                     r_we;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_abort;
    logic                     w_go;
    logic                     w_spi_rst;
    logic [c_CODE_BITS-1:0]   w_spi_data;
    logic                     w_spi_valid;

    assign w_abort   = abort && r_busy;
    assign w_go      = (r_state == c_ST_WAIT) && (r_timer == '0) && !abort;
    // Aborting returns the ADC interface to idle in the same cycle as the FSM.
    assign w_spi_rst = rst || w_abort;

    mic_spi_rx #(
        .SCLK_HALF (SCLK_HALF)
    ) u_spi (
        .clk   (clk),
        .rst   (w_spi_rst),
        .go    (w_go),
        .sdata (mic_sdata),
        .cs_n  (mic_cs_n),
        .sclk  (mic_sclk),
        .data  (w_spi_data),
        .valid (w_spi_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_timer <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;

            // Free-running through WAIT/CONV/WRITE so the sample period does
            // not depend on conversion latency.
            if (r_state != c_ST_IDLE) begin
                r_timer <= (r_timer == c_TIMER_MAX) ? '0 : r_timer + c_TIMER_W'(1);
            end

            if (w_abort) begin
                r_state <= c_ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start && !abort) begin
                            r_state <= c_ST_WAIT;
                            r_timer <= '0;
                            r_addr  <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    c_ST_WAIT: begin
                        if (r_timer == '0) begin
                            r_state <= c_ST_CONV;
                        end
                    end
                    c_ST_CONV: begin
                        if (w_spi_valid) begin
                            r_state <= c_ST_WRITE;
                            r_we    <= 1'b1;
                            r_din   <= code_to_pcm(w_spi_data);
                        end
                    end
                    c_ST_WRITE: begin
                        if (r_addr == c_LAST_ADDR) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_WAIT;
                            r_addr  <= r_addr + c_ADDR_BITS'(1);
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_we   = r_we;
    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_audio_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_recorder
// Description : Directed self-checking bench for audio_recorder with a
//               shortened recording (HOLD_TIME=1000, MUSIC_LEN=4). A simple
//               ADC model shifts out a per-sample 16-bit word, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_recorder;

    localparam int c_HOLD = 1000;
    localparam int c_LEN  = 4;
    localparam int c_HALF = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        mic_sdata;
    logic        mic_cs_n;
    logic        mic_sclk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        busy;
    logic        done;

    audio_recorder #(
        .HOLD_TIME (c_HOLD),
        .MUSIC_LEN (c_LEN),
        .SCLK_HALF (c_HALF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mic_sdata (mic_sdata),
        .mic_cs_n  (mic_cs_n),
        .mic_sclk  (mic_sclk),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Bench bookkeeping, written only by the stimulus process.
    int          total = 0;
    int          bad   = 0;
    int          tcyc  = 0;
    int          wr_n  = 0;
    int          done_n = 0;
    int          wa [8];
    int          wd [8];
    int          wc [8];
    int          s;
    int          rises;
    logic        prev_sclk;
    logic [15:0] adc_tab [4];

    // ADC model: bit index restarts at 15 while deselected and steps after
    // every rising SCLK, so the DUT sees the next bit before its next rise.
    logic [3:0]  adc_idx = 4'd15;
    always @(posedge mic_sclk or posedge mic_cs_n) begin
        if (mic_cs_n) adc_idx <= 4'd15;
        else          adc_idx <= adc_idx - 4'd1;
    end
    assign mic_sdata = adc_tab[wr_n[1:0]][adc_idx];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        tcyc++;
        if (mem_we === 1'b1) begin
            if (wr_n < 8) begin
                wa[wr_n] = int'(mem_addr);
                wd[wr_n] = int'(mem_din);
                wc[wr_n] = tcyc;
            end
            wr_n++;
        end
        if (done === 1'b1) done_n++;
    endtask

    task automatic run_writes(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (wr_n < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(wr_n >= target), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, 32'(mic_cs_n), 32'd1);
        chk({tag, "_sclk"}, 32'(mic_sclk), 32'd1);
        chk({tag, "_we"},   32'(mem_we),   32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_din"},  32'(mem_din),  32'd0);
        chk({tag, "_busy"}, 32'(busy),     32'd0);
        chk({tag, "_done"}, 32'(done),     32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        // Upper nibbles are junk that the recorder must ignore.
        adc_tab[0] = 16'hAFFF;   // D=0xFFF -> 0x7FF0
        adc_tab[1] = 16'h5000;   // D=0x000 -> 0x8000
        adc_tab[2] = 16'h3800;   // D=0x800 -> 0x0000
        adc_tab[3] = 16'hF123;   // D=0x123 -> (0x123-0x800)<<4 = 0x9230
        repeat (3) step();
        rst = 1'b0;
        step();
        check_reset_outputs("reset");

        // ---- full recording with a stray start in the middle ----
        wr_n = 0; done_n = 0;
        s = tcyc;
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        run_writes("wait_write0", 1, 900);
        // WAIT 1 + conversion 800 + handoff 2 cycles.
        chk("first_write_latency", 32'((wc[0] - s) <= 803), 32'd1);
        run_writes("wait_write2", 2, 1200);
        pulse_start();            // must be ignored while busy
        run_writes("wait_write4", 4, 2500);
        step();
        chk("done_pulse",  32'(done_n), 32'd1);
        chk("busy_fall",   32'(busy),   32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("addr%0d", i), 32'(wa[i]), 32'(i));
        chk("din0_fff", 32'(wd[0]), 32'h7FF0);
        chk("din1_000", 32'(wd[1]), 32'h8000);
        chk("din2_800", 32'(wd[2]), 32'h0000);
        chk("din3_123", 32'(wd[3]), 32'h9230);
        for (int i = 1; i < 4; i++) chk($sformatf("period%0d", i), 32'(wc[i] - wc[i-1]), 32'd1000);
        chk("done_after_last", 32'(done_n), 32'd1);
        repeat (5) step();
        chk("done_single", 32'(done_n), 32'd1);
        chk("addr_hold",   32'(mem_addr), 32'd3);
        chk("idle_busy",   32'(busy), 32'd0);
        chk("writes_total", 32'(wr_n), 32'd4);

        // ---- abort on SCLK rising edge 8 of sample 2 ----
        wr_n = 0; done_n = 0;
        pulse_start();
        run_writes("abort_wait2", 2, 2200);
        rises = 0;
        prev_sclk = mic_sclk;
        for (int n = 0; n < 1200 && rises < 8; n++) begin
            step();
            if (mic_sclk === 1'b1 && prev_sclk === 1'b0) rises++;
            prev_sclk = mic_sclk;
        end
        chk("abort_edge8_seen", 32'(rises), 32'd8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy),     32'd0);
        chk("abort_cs_n", 32'(mic_cs_n), 32'd1);
        chk("abort_sclk", 32'(mic_sclk), 32'd1);
        repeat (1500) step();
        chk("abort_no_write", 32'(wr_n),   32'd2);
        chk("abort_no_done",  32'(done_n), 32'd0);

        // abort and start together in IDLE: stays idle
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        repeat (1200) step();
        chk("abort_start_no_write", 32'(wr_n), 32'd2);

        // ---- reset during WAIT, then a clean restart ----
        wr_n = 0;
        pulse_start();
        run_writes("rwait_w0", 1, 900);
        repeat (50) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_wait");
        wr_n = 0;
        pulse_start();
        run_writes("restart_w0", 1, 900);
        chk("restart_addr", 32'(wa[0]), 32'd0);
        chk("restart_din",  32'(wd[0]), 32'h7FF0);

        // ---- reset during CONV of the following sample ----
        repeat (400) step();
        chk("in_conv_cs", 32'(mic_cs_n), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_conv");
        repeat (1200) step();
        chk("rst_conv_no_write", 32'(wr_n), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
